// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite compositor.
// Sprite state payload, default transparency key and screen geometry.
package sprite_pkg;

    localparam int unsigned SCREEN_W      = 640;
    localparam int unsigned SCREEN_H      = 480;
    localparam int unsigned POS_W         = 10;
    localparam int unsigned FRAME_FIELD_W = 8;

    localparam logic [5:0] DEFAULT_KEY_RGB = 6'b110011;

    typedef struct packed {
        logic [POS_W-1:0]         x;
        logic [POS_W-1:0]         y;
        logic [FRAME_FIELD_W-1:0] frame;
        logic                     vis;
        logic                     flip;
    } sprite_state_t;

    // Width of a select field able to index n items, never below one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_channel.sv
// One sprite channel: shadow/active state, hit test and registered ROM address.
// Automatic animation is compiled in when SPRITE_ANIM_EN is defined.
module sprite_channel
    import sprite_pkg::*;
#(
    parameter int unsigned SPR_W       = 30,
    parameter int unsigned SPR_H       = 40,
    parameter int unsigned ANIM_FRAMES = 4,
    parameter int unsigned ANIM_DIV    = 8,
    parameter int unsigned ADDR_W      = $clog2(SPR_W * SPR_H * ANIM_FRAMES),
    parameter int unsigned FRAME_W     = clog2_min1(ANIM_FRAMES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         col,
    input  logic [9:0]         row,
    input  logic               frame_tick,
    input  logic               wr_en,
    input  logic [9:0]         wr_x,
    input  logic [9:0]         wr_y,
    input  logic [FRAME_W-1:0] wr_frame,
    input  logic               wr_vis,
    input  logic               wr_flip,
    output logic [ADDR_W-1:0]  spr_addr,
    output logic               hit_d2
);

    localparam int unsigned SPR_PIX = SPR_W * SPR_H;

    sprite_state_t     r_shadow;
    sprite_state_t     r_active;
    logic              r_dirty;
    logic [ADDR_W-1:0] r_addr;
    logic              r_hit_d1;
    logic              r_hit_d2;

    sprite_state_t     w_wr_state;
    sprite_state_t     w_commit_state;
    logic              w_commit;
    logic [10:0]       w_col11;
    logic [10:0]       w_row11;
    logic [10:0]       w_x11;
    logic [10:0]       w_y11;
    logic              w_hit;
    logic [9:0]        w_dx;
    logic [9:0]        w_dy;
    logic [9:0]        w_cx;
    logic [ADDR_W-1:0] w_addr;

    assign w_wr_state = '{x: wr_x, y: wr_y, frame: FRAME_FIELD_W'(wr_frame),
                          vis: wr_vis, flip: wr_flip};

    // A write landing on the tick cycle is folded into that commit.
    assign w_commit       = frame_tick && (wr_en || r_dirty);
    assign w_commit_state = wr_en ? w_wr_state : r_shadow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow <= '0;
            r_dirty  <= 1'b0;
        end else begin
            if (wr_en) begin
                r_shadow <= w_wr_state;
            end
            if (frame_tick) begin
                r_dirty <= 1'b0;
            end else if (wr_en) begin
                r_dirty <= 1'b1;
            end
        end
    end

`ifdef SPRITE_ANIM_EN
    localparam int unsigned DIV_W = clog2_min1(ANIM_DIV);

    logic [DIV_W-1:0]         r_div;
    logic [FRAME_FIELD_W-1:0] w_next_frame;

    assign w_next_frame = (r_active.frame == FRAME_FIELD_W'(ANIM_FRAMES - 1))
                        ? '0 : r_active.frame + FRAME_FIELD_W'(1);

    // Clean sprites step their frame once every ANIM_DIV ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_active <= '0;
            r_div    <= '0;
        end else if (w_commit) begin
            r_active <= w_commit_state;
            r_div    <= '0;
        end else if (frame_tick) begin
            if (r_div == DIV_W'(ANIM_DIV - 1)) begin
                r_div <= '0;
                if (r_active.vis) begin
                    r_active.frame <= w_next_frame;
                end
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            r_active <= '0;
        end else if (w_commit) begin
            r_active <= w_commit_state;
        end
    end
`endif

    // Compare in 11 bits so a sprite near the right/bottom edge clips instead of wrapping.
    assign w_col11 = {1'b0, col};
    assign w_row11 = {1'b0, row};
    assign w_x11   = {1'b0, r_active.x};
    assign w_y11   = {1'b0, r_active.y};

    assign w_hit = r_active.vis
                && (w_col11 >= w_x11) && (w_col11 < w_x11 + 11'(SPR_W))
                && (w_row11 >= w_y11) && (w_row11 < w_y11 + 11'(SPR_H));

    assign w_dx   = col - r_active.x;
    assign w_dy   = row - r_active.y;
    assign w_cx   = r_active.flip ? (10'(SPR_W - 1) - w_dx) : w_dx;
    assign w_addr = ADDR_W'(r_active.frame) * ADDR_W'(SPR_PIX)
                  + ADDR_W'(w_dy) * ADDR_W'(SPR_W)
                  + ADDR_W'(w_cx);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr   <= '0;
            r_hit_d1 <= 1'b0;
            r_hit_d2 <= 1'b0;
        end else begin
            r_addr   <= w_hit ? w_addr : '0;
            r_hit_d1 <= w_hit;
            r_hit_d2 <= r_hit_d1;
        end
    end

    assign spr_addr = r_addr;
    assign hit_d2   = r_hit_d2;

endmodule

// File: rtl/sprite_compositor.sv
// Multi-sprite overlay stage: per-sprite channels, priority mux, valid delay and collision flag.
// Define SPRITE_ANIM_EN to enable per-sprite automatic animation.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int unsigned N_SPRITES   = 4,
    parameter int unsigned SPR_W       = 30,
    parameter int unsigned SPR_H       = 40,
    parameter int unsigned ANIM_FRAMES = 4,
    parameter int unsigned ANIM_DIV    = 8,
    parameter int unsigned RGB_W       = 6,
    parameter logic [RGB_W-1:0] KEY_RGB = RGB_W'(DEFAULT_KEY_RGB),
    parameter int unsigned ADDR_W      = $clog2(SPR_W * SPR_H * ANIM_FRAMES),
    parameter int unsigned SEL_W       = clog2_min1(N_SPRITES),
    parameter int unsigned FRAME_W     = clog2_min1(ANIM_FRAMES)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [9:0]                    col,
    input  logic [9:0]                    row,
    input  logic                          valid,
    input  logic                          frame_tick,
    input  logic                          wr_en,
    input  logic [SEL_W-1:0]              wr_sel,
    input  logic [9:0]                    wr_x,
    input  logic [9:0]                    wr_y,
    input  logic [FRAME_W-1:0]            wr_frame,
    input  logic                          wr_vis,
    input  logic                          wr_flip,
    output logic [N_SPRITES*ADDR_W-1:0]   spr_addr,
    input  logic [N_SPRITES*RGB_W-1:0]    spr_data,
    input  logic [RGB_W-1:0]              tile_rgb,
    output logic [RGB_W-1:0]              rgb_out,
    output logic                          valid_out,
    output logic [N_SPRITES-1:0]          hit_mask,
    output logic                          collision
);

    logic [N_SPRITES-1:0] w_hit_d2;
    logic [N_SPRITES-1:0] w_opaque;
    logic [RGB_W-1:0]     w_rgb;
    logic                 w_multi;

    logic                 r_valid_d1;
    logic                 r_valid_d2;
    logic                 r_valid_out;
    logic [RGB_W-1:0]     r_rgb;
    logic [N_SPRITES-1:0] r_hit_mask;
    logic                 r_collision;

    for (genvar gi = 0; gi < N_SPRITES; gi++) begin : g_chan
        sprite_channel #(
            .SPR_W       (SPR_W),
            .SPR_H       (SPR_H),
            .ANIM_FRAMES (ANIM_FRAMES),
            .ANIM_DIV    (ANIM_DIV),
            .ADDR_W      (ADDR_W),
            .FRAME_W     (FRAME_W)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .col        (col),
            .row        (row),
            .frame_tick (frame_tick),
            .wr_en      (wr_en && (wr_sel == SEL_W'(gi))),
            .wr_x       (wr_x),
            .wr_y       (wr_y),
            .wr_frame   (wr_frame),
            .wr_vis     (wr_vis),
            .wr_flip    (wr_flip),
            .spr_addr   (spr_addr[gi*ADDR_W +: ADDR_W]),
            .hit_d2     (w_hit_d2[gi])
        );
    end

    // Lowest-index opaque sprite wins; blanking forces black.
    always_comb begin
        w_opaque = '0;
        w_rgb    = tile_rgb;
        for (int i = 0; i < N_SPRITES; i++) begin
            w_opaque[i] = w_hit_d2[i] && (spr_data[i*RGB_W +: RGB_W] != KEY_RGB);
        end
        for (int i = N_SPRITES - 1; i >= 0; i--) begin
            if (w_opaque[i]) begin
                w_rgb = spr_data[i*RGB_W +: RGB_W];
            end
        end
        if (!r_valid_d2) begin
            w_rgb = '0;
        end
    end

    assign w_multi = (w_opaque & (w_opaque - N_SPRITES'(1))) != '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid_d1  <= 1'b0;
            r_valid_d2  <= 1'b0;
            r_valid_out <= 1'b0;
            r_rgb       <= '0;
            r_hit_mask  <= '0;
            r_collision <= 1'b0;
        end else begin
            r_valid_d1  <= valid;
            r_valid_d2  <= r_valid_d1;
            r_valid_out <= r_valid_d2;
            r_rgb       <= w_rgb;
            r_hit_mask  <= w_opaque;
            // Overlap set takes precedence over the frame clear.
            if (r_valid_d2 && w_multi) begin
                r_collision <= 1'b1;
            end else if (frame_tick) begin
                r_collision <= 1'b0;
            end
        end
    end

    assign rgb_out   = r_rgb;
    assign valid_out = r_valid_out;
    assign hit_mask  = r_hit_mask;
    assign collision = r_collision;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed, table-driven bench for sprite_compositor (default parameters).
module tb_sprite_compositor;

    localparam logic [5:0] KEY  = 6'b110011;
    localparam logic [5:0] TILE = 6'h2A;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  col, row;
    logic        valid;
    logic        frame_tick;
    logic        wr_en;
    logic [1:0]  wr_sel;
    logic [9:0]  wr_x, wr_y;
    logic [1:0]  wr_frame;
    logic        wr_vis, wr_flip;
    logic [51:0] spr_addr;
    logic [23:0] spr_data;
    logic [5:0]  tile_rgb;
    logic [5:0]  rgb_out;
    logic        valid_out;
    logic [3:0]  hit_mask;
    logic        collision;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sprite_compositor dut (
        .clk        (clk),
        .reset      (reset),
        .col        (col),
        .row        (row),
        .valid      (valid),
        .frame_tick (frame_tick),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_frame   (wr_frame),
        .wr_vis     (wr_vis),
        .wr_flip    (wr_flip),
        .spr_addr   (spr_addr),
        .spr_data   (spr_data),
        .tile_rgb   (tile_rgb),
        .rgb_out    (rgb_out),
        .valid_out  (valid_out),
        .hit_mask   (hit_mask),
        .collision  (collision)
    );

    typedef struct {
        logic [9:0]  col;
        logic [9:0]  row;
        logic        vld;
        logic [5:0]  d0;
        logic [5:0]  d1;
        logic [12:0] e_a0;
        logic [12:0] e_a1;
        logic [5:0]  e_rgb;
        logic [3:0]  e_mask;
    } vec_t;

    function automatic vec_t mk(input int c, input int r, input logic v,
                                input logic [5:0] d0, input logic [5:0] d1,
                                input int a0, input int a1,
                                input logic [5:0] rgb, input logic [3:0] mask);
        vec_t t;
        t.col = 10'(c); t.row = 10'(r); t.vld = v; t.d0 = d0; t.d1 = d1;
        t.e_a0 = 13'(a0); t.e_a1 = 13'(a1); t.e_rgb = rgb; t.e_mask = mask;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic wr(input int sel, input int x, input int y, input int fr,
                      input logic vis, input logic flip, input logic with_tick);
        wr_en = 1'b1; wr_sel = 2'(sel); wr_x = 10'(x); wr_y = 10'(y);
        wr_frame = 2'(fr); wr_vis = vis; wr_flip = flip; frame_tick = with_tick;
        tick();
        wr_en = 1'b0; frame_tick = 1'b0;
    endtask

    task automatic ftick(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
            tick();
        end
    endtask

    // Hold one pixel until the pipeline is full of it, then check every output.
    task automatic run_vec(input string nm, input vec_t v);
        col = v.col; row = v.row; valid = v.vld;
        spr_data = {6'h3F, 6'h3F, v.d1, v.d0};
        tile_rgb = TILE;
        repeat (4) tick();
        chk({nm, ".addr0"}, 32'(spr_addr[12:0]),  32'(v.e_a0));
        chk({nm, ".addr1"}, 32'(spr_addr[25:13]), 32'(v.e_a1));
        chk({nm, ".rgb"},   32'(rgb_out),         32'(v.e_rgb));
        chk({nm, ".mask"},  32'(hit_mask),        32'(v.e_mask));
    endtask

    vec_t ta[8];
    vec_t tb[4];
    vec_t tc[3];
    vec_t td[4];
    vec_t te[2];

    initial begin
        ta[0] = mk(100, 50, 1, 6'h05, 6'h22, 0,    0, 6'h05, 4'b0001);
        ta[1] = mk(129, 89, 1, 6'h05, 6'h22, 1199, 0, 6'h05, 4'b0001);
        ta[2] = mk(130, 89, 1, 6'h05, 6'h22, 0,    0, TILE,  4'b0000);
        ta[3] = mk(99,  50, 1, 6'h05, 6'h22, 0,    0, TILE,  4'b0000);
        ta[4] = mk(100, 90, 1, 6'h05, 6'h22, 0,    0, TILE,  4'b0000);
        ta[5] = mk(110, 60, 1, 6'h05, 6'h22, 310,  0, 6'h05, 4'b0001);
        ta[6] = mk(101, 50, 1, KEY,   6'h22, 1,    0, TILE,  4'b0000);
        ta[7] = mk(300, 300, 0, 6'h05, 6'h22, 0,   0, 6'h00, 4'b0000);

        tb[0] = mk(100, 50, 1, 6'h05, 6'h22, 29,   0, 6'h05, 4'b0001);
        tb[1] = mk(129, 50, 1, 6'h05, 6'h22, 0,    0, 6'h05, 4'b0001);
        tb[2] = mk(110, 51, 1, 6'h05, 6'h22, 49,   0, 6'h05, 4'b0001);
        tb[3] = mk(100, 50, 1, 6'h05, 6'h22, 2429, 0, 6'h05, 4'b0001);

        tc[0] = mk(120, 70, 1, 6'h11, 6'h22, 620, 310, 6'h11, 4'b0011);
        tc[1] = mk(120, 70, 1, KEY,   6'h22, 620, 310, 6'h22, 4'b0010);
        tc[2] = mk(105, 55, 1, 6'h11, 6'h22, 155, 0,   6'h11, 4'b0001);

        td[0] = mk(105, 55, 1, 6'h11, 6'h22, 155, 0, 6'h11, 4'b0001);
        td[1] = mk(105, 55, 1, 6'h11, 6'h22, 0,   0, TILE,  4'b0000);
        td[2] = mk(200, 50, 1, 6'h11, 6'h22, 0,   0, TILE,  4'b0000);
        td[3] = mk(301, 51, 1, 6'h11, 6'h22, 31,  0, 6'h11, 4'b0001);

        te[0] = mk(639, 50, 1, 6'h11, 6'h22, 19, 0, 6'h11, 4'b0001);
        te[1] = mk(0,   50, 1, 6'h11, 6'h22, 0,  0, TILE,  4'b0000);

        reset = 1'b1; col = '0; row = '0; valid = 1'b0; frame_tick = 1'b0;
        wr_en = 1'b0; wr_sel = '0; wr_x = '0; wr_y = '0; wr_frame = '0;
        wr_vis = 1'b0; wr_flip = 1'b0; spr_data = '0; tile_rgb = TILE;
        repeat (3) tick();
        chk("rst.rgb",   32'(rgb_out),   0);
        chk("rst.vout",  32'(valid_out), 0);
        chk("rst.mask",  32'(hit_mask),  0);
        chk("rst.coll",  32'(collision), 0);
        chk("rst.addr",  32'(spr_addr != '0), 0);
        reset = 1'b0;
        tick();

        // Single sprite, no flip, frame 0
        wr(0, 100, 50, 0, 1'b1, 1'b0, 1'b0);
        ftick(1);
        for (int i = 0; i < 8; i++) run_vec($sformatf("A%0d", i), ta[i]);

        // One-pixel pulse to check the 1/3-cycle latencies
        col = 10'd129; row = 10'd89; valid = 1'b1; spr_data = {6'h3F, 6'h3F, 6'h22, 6'h05};
        tick();
        chk("lat.addr_t1", 32'(spr_addr[12:0]), 1199);
        col = 10'd0; row = 10'd0; valid = 1'b0;
        tick();
        chk("lat.addr_t2", 32'(spr_addr[12:0]), 0);
        chk("lat.vout_t2", 32'(valid_out), 0);
        tick();
        chk("lat.rgb_t3",  32'(rgb_out), 32'(6'h05));
        chk("lat.vout_t3", 32'(valid_out), 1);
        chk("lat.mask_t3", 32'(hit_mask), 1);
        tick();
        chk("lat.vout_t4", 32'(valid_out), 0);
        chk("lat.rgb_t4",  32'(rgb_out), 0);

        // Horizontal flip, then flip with frame 2
        wr(0, 100, 50, 0, 1'b1, 1'b1, 1'b0);
        ftick(1);
        for (int i = 0; i < 3; i++) run_vec($sformatf("B%0d", i), tb[i]);
        wr(0, 100, 50, 2, 1'b1, 1'b1, 1'b0);
        ftick(1);
        run_vec("B3", tb[3]);

        // Overlap, keying and sticky collision
        chk("coll.before", 32'(collision), 0);
        wr(0, 100, 50, 0, 1'b1, 1'b0, 1'b0);
        wr(1, 110, 60, 0, 1'b1, 1'b0, 1'b0);
        ftick(1);
        run_vec("C0", tc[0]);
        chk("C0.coll", 32'(collision), 1);
        run_vec("C1", tc[1]);
        run_vec("C2", tc[2]);
        chk("C2.coll_sticky", 32'(collision), 1);
        ftick(1);
        chk("coll.cleared", 32'(collision), 0);

        // Mid-frame write is deferred; write on the tick cycle is committed
        wr(0, 200, 50, 0, 1'b1, 1'b0, 1'b0);
        run_vec("D0", td[0]);
        wr(0, 300, 50, 0, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i < 4; i++) run_vec($sformatf("D%0d", i), td[i]);

        // Right-edge clipping
        wr(0, 620, 50, 0, 1'b1, 1'b0, 1'b0);
        ftick(1);
        for (int i = 0; i < 2; i++) run_vec($sformatf("E%0d", i), te[i]);

        // Animation stepping (or its absence)
        wr(0, 100, 50, 3, 1'b1, 1'b0, 1'b0);
        ftick(1);
        run_vec("F0", mk(100, 50, 1, 6'h11, 6'h22, 3600, 0, 6'h11, 4'b0001));
`ifdef SPRITE_ANIM_EN
        ftick(7);
        run_vec("F1", mk(100, 50, 1, 6'h11, 6'h22, 3600, 0, 6'h11, 4'b0001));
        ftick(1);
        run_vec("F2", mk(100, 50, 1, 6'h11, 6'h22, 0, 0, 6'h11, 4'b0001));
        wr(0, 100, 50, 1, 1'b1, 1'b0, 1'b0);
        ftick(1);
        run_vec("F3", mk(100, 50, 1, 6'h11, 6'h22, 1200, 0, 6'h11, 4'b0001));
        ftick(7);
        run_vec("F4", mk(100, 50, 1, 6'h11, 6'h22, 1200, 0, 6'h11, 4'b0001));
        ftick(1);
        run_vec("F5", mk(100, 50, 1, 6'h11, 6'h22, 2400, 0, 6'h11, 4'b0001));
`else
        ftick(8);
        run_vec("F1", mk(100, 50, 1, 6'h11, 6'h22, 3600, 0, 6'h11, 4'b0001));
`endif

        // Reset in the middle of active output
        wr(1, 100, 50, 0, 1'b1, 1'b0, 1'b0);
        ftick(1);
        wr(0, 100, 50, 0, 1'b1, 1'b0, 1'b0);
        ftick(1);
        run_vec("G0", mk(100, 50, 1, 6'h11, 6'h22, 0, 0, 6'h11, 4'b0011));
        chk("G0.coll", 32'(collision), 1);
        reset = 1'b1;
        tick();
        chk("G.rst.rgb",  32'(rgb_out),   0);
        chk("G.rst.vout", 32'(valid_out), 0);
        chk("G.rst.mask", 32'(hit_mask),  0);
        chk("G.rst.coll", 32'(collision), 0);
        chk("G.rst.addr", 32'(spr_addr != '0), 0);
        reset = 1'b0;
        run_vec("G1", mk(100, 50, 1, 6'h11, 6'h22, 0, 0, TILE, 4'b0000));
        chk("G1.vout", 32'(valid_out), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised multi-sprite overlay stage between the VGA timing generator and the pattern generator. It composites up to N_SPRITES fixed-size sprites over the background tile colour, with per-pixel transparency keying and fixed priority. Sprite state lives in double-buffered registers that commit on frame_tick, so updates never tear mid-frame. The block also provides optional automatic animation, horizontal flip, per-pixel hit reporting and a per-frame collision flag. Sprite-sheet ROMs stay external, one synchronous ROM per sprite.

## Interface
- N_SPRITES, 4: number of sprite channels; index 0 has the highest priority.
- SPR_W, 30 / SPR_H, 40: sprite size in pixels.
- ANIM_FRAMES, 4: frames per sheet, stacked linearly in ROM.
- ANIM_DIV, 8: frame_ticks per automatic animation step.
- RGB_W, 6: colour width.
- KEY_RGB, 6'b110011: transparent colour key.
- ADDR_W, derived as $clog2(SPR_W*SPR_H*ANIM_FRAMES): ROM address width.
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high.
- col, row  in  10 each  current pixel position from the VGA timing generator.
- valid  in  1  visible-area flag.
- frame_tick  in  1  one-cycle pulse per frame, during vblank.
- wr_en  in  1  write strobe for sprite state.
- wr_sel  in  $clog2(N_SPRITES)  selects the sprite to write.
- wr_x, wr_y  in  10 each  top-left position.
- wr_frame  in  $clog2(ANIM_FRAMES)  animation frame.
- wr_vis  in  1  visible.
- wr_flip  in  1  horizontal mirror.
- spr_addr  out  N_SPRITES*ADDR_W  per-sprite ROM address, registered.
- spr_data  in  N_SPRITES*RGB_W  per-sprite ROM data; the ROM has one cycle of latency.
- tile_rgb  in  RGB_W  background colour.
- rgb_out  out  RGB_W  composited colour.
- valid_out  out  1  valid, delayed to align with rgb_out.
- hit_mask  out  N_SPRITES  opaque-hit bit per sprite, aligned with rgb_out.
- collision  out  1  sticky overlap flag for the current frame.

## Operation
- Shadow set: x, y, frame, vis, flip and a dirty bit per sprite.
  - wr_en writes the wr_sel entry and sets its dirty bit.
- Active set: copied from shadow on frame_tick.
  - A write in the same cycle as frame_tick is included in that commit (bypass).
  - Dirty bits clear on commit.
- Hit test per sprite: col >= x && col < x+SPR_W && row >= y && row < y+SPR_H && vis.
  - All comparisons are done in 11 bits, so sprites extending past 639/479 clip and never wrap.
- Address calculation:
  - dx = col-x, dy = row-y.
  - cx = flip ? SPR_W-1-dx : dx.
  - addr = frame*SPR_W*SPR_H + dy*SPR_W + cx.
  - A sprite with no hit gets addr 0.
- Opaque test: sprite i is opaque when its delayed hit is set and spr_data[i] != KEY_RGB.
- Output colour:
  - rgb_out = spr_data of the lowest-index opaque sprite; otherwise tile_rgb.
  - rgb_out is forced to 0 when the delayed valid is low.
- Collision: set when two or more bits of hit_mask are set in a valid pixel. It holds until the next frame_tick, which clears it. If a set and a clear land in the same cycle, the set wins.
- Reset: all sprites invisible, positions/frames/flip 0, dirty 0, animation dividers 0. All outputs 0.

## Timing
- Pixel presented at cycle t (col/row/valid).
- spr_addr is valid at t+1.
- spr_data and tile_rgb must both be presented at t+2. The caller delays the background ROM output by one cycle.
- rgb_out, valid_out, hit_mask and collision update at t+3. Total latency is 3 cycles, fully pipelined at 1 pixel per clock.
- State changes take effect from the first pixel after the frame_tick cycle, never mid-frame.
- Reset asserted mid-frame clears the pipeline. Outputs read 0 on the cycle after reset is sampled high.

## Configuration
- SPRITE_ANIM_EN defined: each sprite has a divider counting frame_ticks 0..ANIM_DIV-1.
  - On wrap, a visible, non-dirty sprite advances its active frame: ANIM_FRAMES-1 wraps to 0.
  - A dirty commit loads wr_frame and resets that sprite's divider.
- SPRITE_ANIM_EN undefined: no dividers. The frame changes only through writes.

## Structure
- Package sprite_pkg:
  - sprite_state_t struct (x, y, frame, vis, flip).
  - Default KEY_RGB.
  - Screen constants 640/480.
- Sub-module sprite_channel: one per sprite, created with a generate loop. It holds the shadow/active registers, the divider, the hit test and the address register, and exports a hit flag delayed to t+2.
- The top level holds the priority mux, the valid delay line and the collision logic.

## Test plan
- Write sprite 0 at x=100,y=50, vis=1, then frame_tick. At col=100,row=50, spr_addr[0]=0 at t+1. At col=129,row=89 it is 1199. col=130 gives no hit and rgb_out = tile_rgb.
- Set flip=1. At col=100,row=50, addr=29.
  - With frame=2, the same pixel gives addr=2429.
- Place sprites 0 and 1 overlapping, both with opaque data.
  - rgb_out = spr_data[0], hit_mask=2'b11, collision=1 until the next frame_tick.
  - When sprite 0's data = 6'b110011, rgb_out = spr_data[1] and hit_mask=2'b10.
- Write x=200 mid-frame: the output is unchanged until frame_tick.
  - Write and frame_tick in the same cycle: the new x is active on the next frame.
- With SPRITE_ANIM_EN and ANIM_DIV=8: the frame advances every 8 ticks, going 3 to 0 on wrap. A write of frame=1 reloads the frame and resets the divider.
- Sprite at x=620: it clips at col 639 with no hit at col 0.
  - Reset mid-frame: all outputs read 0 the next cycle and every sprite is invisible.
